// File: rtl/fp_div_seq_pkg.sv
// Shared definitions for the sequential FP divide front-end: state codes, flag layout, constants.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package fp_div_seq_pkg;

    // Controller state encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    // Response / sticky flag vector layout {timeout,inv,div_zero,ov,un,inexact}
    localparam int FLAG_W      = 6;
    localparam int FL_TIMEOUT  = 5;
    localparam int FL_INV      = 4;
    localparam int FL_DIV_ZERO = 3;
    localparam int FL_OV       = 2;
    localparam int FL_UN       = 1;
    localparam int FL_INEXACT  = 0;

    // Result substituted when the divider never reports completion
    localparam logic [31:0]       QNAN_32       = 32'h7FC0_0000;
    localparam logic [FLAG_W-1:0] TIMEOUT_FLAGS = 6'b110000;

    // IEEE-754 rounding mode codes as driven on div_round_m
    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    // Assemble a flag vector in the canonical bit order
    function automatic logic [FLAG_W-1:0] pack_flags(
        input logic timeout,
        input logic inv,
        input logic div_zero,
        input logic ov,
        input logic un,
        input logic inexact
    );
        logic [FLAG_W-1:0] f;
        f              = '0;
        f[FL_TIMEOUT]  = timeout;
        f[FL_INV]      = inv;
        f[FL_DIV_ZERO] = div_zero;
        f[FL_OV]       = ov;
        f[FL_UN]       = un;
        f[FL_INEXACT]  = inexact;
        return f;
    endfunction

endpackage

// File: rtl/fp_div_seq.sv
// Sequencer that issues one divide to an external FP divider and returns its result with flags.
// Latency: 1 + MIN_LAT + k + 1 cycles from request handshake to rsp_valid (k = WAIT cycles before done).
// Backpressure: one op in flight; req_ready only in IDLE, response held in RESP until rsp_ready.
module fp_div_seq
    import fp_div_seq_pkg::*;
#(
    parameter int W       = 32,
    parameter int MIN_LAT = 3,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic [W-1:0]      req_a,
    input  logic [W-1:0]      req_b,
    input  logic [2:0]        req_rm,

    output logic              div_act,
    output logic [W-1:0]      div_in1,
    output logic [W-1:0]      div_in2,
    output logic [2:0]        div_round_m,

    input  logic [W-1:0]      div_out,
    input  logic              div_ov,
    input  logic              div_un,
    input  logic              div_done,
    input  logic              div_inv,
    input  logic              div_div_zero,
    input  logic              div_inexact,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [W-1:0]      rsp_data,
    output logic [FLAG_W-1:0] rsp_flags,

    output logic [FLAG_W-1:0] sticky_flags,
    input  logic              clr_flags
);

    // One shared counter serves both the settle window and the timeout window,
    // so it is sized for the larger of the two and saturates at that bound.
    localparam int CNT_MAX = (MIN_LAT > TIMEOUT) ? MIN_LAT : TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX + 1);

    // Last counter value of each window; a zero-length window still spends one cycle.
    localparam logic [CW-1:0] SETTLE_LAST = CW'((MIN_LAT > 0) ? MIN_LAT - 1 : 0);
    localparam logic [CW-1:0] WAIT_LAST   = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CW-1:0] CNT_SAT     = CW'(CNT_MAX);

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [CW-1:0] cnt_inc;

    logic          issue;
    logic          capture;
    logic          expire;
    logic          rsp_hs;

    // Saturating increment: the counter pins at its maximum instead of wrapping
    always_comb begin
        cnt_inc = cnt;
        if (cnt != CNT_SAT) begin
            cnt_inc = cnt + CW'(1);
        end
    end

    // Next-state decode and event strobes for the datapath registers
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        issue     = 1'b0;
        capture   = 1'b0;
        expire    = 1'b0;
        rsp_hs    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    issue     = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                // div_done is deliberately not looked at here: the divider may
                // still be showing the previous operation's completion.
                if (cnt == SETTLE_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_WAIT;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            ST_WAIT: begin
                // A done seen on the final timeout cycle still counts as a real result.
                if (div_done) begin
                    capture   = 1'b1;
                    state_nxt = ST_RESP;
                end else if (cnt == WAIT_LAST) begin
                    expire    = 1'b1;
                    state_nxt = ST_RESP;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_hs    = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Handshake outputs follow the registered state directly
    assign req_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);

    // State and window counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Divider operands: captured at issue and otherwise untouched, so they stay
    // stable through the whole operation including the response phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_in1     <= '0;
            div_in2     <= '0;
            div_round_m <= '0;
        end else if (issue) begin
            div_in1     <= req_a;
            div_in2     <= req_b;
            div_round_m <= req_rm;
        end
    end

    // Divider activity: raised at issue, dropped once a result or timeout is taken
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_act <= 1'b0;
        end else if (issue) begin
            div_act <= 1'b1;
        end else if (capture || expire) begin
            div_act <= 1'b0;
        end
    end

    // Response registers: divider result on done, quiet NaN with timeout+invalid on expiry
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_data  <= '0;
            rsp_flags <= '0;
        end else if (capture) begin
            rsp_data  <= div_out;
            rsp_flags <= pack_flags(1'b0, div_inv, div_div_zero, div_ov, div_un, div_inexact);
        end else if (expire) begin
            rsp_data  <= W'(QNAN_32);
            rsp_flags <= TIMEOUT_FLAGS;
        end
    end

    // Sticky accumulation; a clear coinciding with a handshake keeps only that response's flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sticky_flags <= '0;
        end else if (rsp_hs) begin
            sticky_flags <= clr_flags ? rsp_flags : (sticky_flags | rsp_flags);
        end else if (clr_flags) begin
            sticky_flags <= '0;
        end
    end

endmodule

// File: tb/tb_fp_div_seq.sv
`timescale 1ns/1ps
module tb_fp_div_seq;
    import fp_div_seq_pkg::*;

    localparam int W       = 32;
    localparam int MIN_LAT = 3;
    localparam int TIMEOUT = 64;
    localparam int NEVER   = 1000;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [W-1:0]  req_a = '0;
    logic [W-1:0]  req_b = '0;
    logic [2:0]    req_rm = '0;
    logic          div_act;
    logic [W-1:0]  div_in1;
    logic [W-1:0]  div_in2;
    logic [2:0]    div_round_m;
    logic [W-1:0]  div_out = '0;
    logic          div_ov = 1'b0;
    logic          div_un = 1'b0;
    logic          div_done = 1'b0;
    logic          div_inv = 1'b0;
    logic          div_div_zero = 1'b0;
    logic          div_inexact = 1'b0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [W-1:0]  rsp_data;
    logic [5:0]    rsp_flags;
    logic [5:0]    sticky_flags;
    logic          clr_flags = 1'b0;

    always #5 clk = ~clk;

    fp_div_seq #(.W(W), .MIN_LAT(MIN_LAT), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_rm(req_rm),
        .div_act(div_act), .div_in1(div_in1), .div_in2(div_in2), .div_round_m(div_round_m),
        .div_out(div_out), .div_ov(div_ov), .div_un(div_un), .div_done(div_done),
        .div_inv(div_inv), .div_div_zero(div_div_zero), .div_inexact(div_inexact),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_flags(rsp_flags),
        .sticky_flags(sticky_flags), .clr_flags(clr_flags)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h cyc=%0d", nm, act, exp, cyc);
        end
    endtask

    // Current operation as programmed by the stimulus: divider answer and its delay
    logic [31:0] op_out   = '0;
    logic [4:0]  op_f5    = '0;   // {inv,div_zero,ov,un,inexact}
    int          op_d     = 0;    // done arrives this many cycles after the settle window
    int          op_stale = -1;   // cycle offset from issue of a bogus done pulse (-1 none)

    // Behavioural model: an accepted op at cycle T answers at cycle R, holds until taken
    bit          m_busy   = 1'b0;
    int          m_t      = 0;
    int          m_r      = 0;
    logic [31:0] m_a, m_b, m_data;
    logic [2:0]  m_rm;
    logic [5:0]  m_flags;
    logic [5:0]  m_sticky = '0;
    int          done_cyc = -1;
    int          stale_cyc = -1;

    always @(posedge clk) begin
        bit was_busy;
        if (!rst) begin
            m_busy   = 1'b0;
            m_sticky = '0;
        end else begin
            was_busy = m_busy;
            if (m_busy && cyc >= m_r && rsp_ready) begin
                m_busy   = 1'b0;
                m_sticky = clr_flags ? m_flags : (m_sticky | m_flags);
            end else if (clr_flags) begin
                m_sticky = '0;
            end
            if (!was_busy && req_valid) begin
                m_busy = 1'b1;
                m_t    = cyc;
                m_a    = req_a;
                m_b    = req_b;
                m_rm   = req_rm;
                if (op_d < TIMEOUT) begin
                    m_r     = cyc + 2 + MIN_LAT + op_d;
                    m_data  = op_out;
                    m_flags = {1'b0, op_f5};
                end else begin
                    m_r     = cyc + 1 + MIN_LAT + TIMEOUT;
                    m_data  = 32'h7FC0_0000;
                    m_flags = 6'b110000;
                end
                done_cyc  = cyc + 1 + MIN_LAT + op_d;
                stale_cyc = (op_stale < 0) ? -1 : cyc + op_stale;
            end
        end
        cyc++;
    end

    // Divider stand-in: real result on done_cyc, garbage on the stale pulse
    always @(posedge clk) begin
        #1;
        div_done = 1'b0; div_out = 32'h0BAD_0BAD;
        {div_inv, div_div_zero, div_ov, div_un, div_inexact} = 5'b0;
        if (m_busy && cyc < m_r && cyc == done_cyc) begin
            div_done = 1'b1; div_out = op_out;
            {div_inv, div_div_zero, div_ov, div_un, div_inexact} = op_f5;
        end else if (m_busy && cyc == stale_cyc) begin
            div_done = 1'b1; div_out = 32'hDEAD_BEEF;
            {div_inv, div_div_zero, div_ov, div_un, div_inexact} = 5'b11111;
        end
    end

    // Cycle-by-cycle comparison of every observable output against the model
    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_req_ready", 64'(req_ready), 64'(1));
            chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
            chk("rst_div_act", 64'(div_act), 64'(0));
            chk("rst_div_in", 64'({div_in1, div_in2}), 64'(0));
            chk("rst_round_m", 64'(div_round_m), 64'(0));
            chk("rst_rsp", 64'({rsp_data, rsp_flags}), 64'(0));
            chk("rst_sticky", 64'(sticky_flags), 64'(0));
        end else begin
            chk("req_ready", 64'(req_ready), 64'(!m_busy));
            chk("rsp_valid", 64'(rsp_valid), 64'(m_busy && cyc >= m_r));
            chk("div_act", 64'(div_act), 64'(m_busy && cyc > m_t && cyc < m_r));
            if (m_busy && cyc > m_t) begin
                chk("div_in1", 64'(div_in1), 64'(m_a));
                chk("div_in2", 64'(div_in2), 64'(m_b));
                chk("div_round_m", 64'(div_round_m), 64'(m_rm));
            end
            if (m_busy && cyc >= m_r) begin
                chk("rsp_data", 64'(rsp_data), 64'(m_data));
                chk("rsp_flags", 64'(rsp_flags), 64'(m_flags));
            end
            chk("sticky", 64'(sticky_flags), 64'(m_sticky));
        end
    end

    // Run one operation; returns observed latency and first response seen
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm,
                         input logic [31:0] out, input logic [4:0] f5, input int d,
                         input int stale, input int hold, input bit clr_hs, input bit junk,
                         output int lat, output logic [31:0] got_d, output logic [5:0] got_f);
        int  t_issue;
        bit  seen;
        op_out = out; op_f5 = f5; op_d = d; op_stale = stale;
        @(posedge clk); #1;
        t_issue = cyc;
        req_valid = 1'b1; req_a = a; req_b = b; req_rm = rm;
        @(posedge clk); #1;
        if (junk) begin
            req_a = ~a; req_b = ~b; req_rm = ~rm; rsp_ready = 1'b1;
        end else begin
            req_valid = 1'b0;
        end
        seen = 1'b0; lat = -1; got_d = '0; got_f = '0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            chk("rsp_wait_expired", 64'(0), 64'(1));
        end else begin
            lat = cyc - t_issue; got_d = rsp_data; got_f = rsp_flags;
        end
        repeat (hold) @(negedge clk);
        if (hold > 0) begin
            chk("held_valid", 64'(rsp_valid), 64'(1));
            chk("held_data", 64'(rsp_data), 64'(got_d));
        end
        rsp_ready = 1'b1;
        clr_flags = clr_hs;
        @(posedge clk); #1;
        rsp_ready = 1'b0; clr_flags = 1'b0; req_valid = 1'b0;
    endtask

    initial begin
        int          lat;
        logic [31:0] d;
        logic [5:0]  f;
        int          vseen;

        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("idle_req_ready", 64'(req_ready), 64'(1));

        // 6.0 / 2.0 = 3.0, done 5 cycles after settle
        do_op(32'h40C00000, 32'h40000000, RM_RNE, 32'h40400000, 5'b00000, 5, -1, 0, 1'b0, 1'b0, lat, d, f);
        chk("op1_lat", 64'(lat), 64'(10));
        chk("op1_data", 64'(d), 64'(32'h40400000));
        chk("op1_flags", 64'(f), 64'(0));

        // 1.0 / 0.0 = +inf with div_zero
        do_op(32'h3F800000, 32'h00000000, RM_RNE, 32'h7F800000, 5'b01000, 2, -1, 0, 1'b0, 1'b0, lat, d, f);
        chk("dz_data", 64'(d), 64'(32'h7F800000));
        chk("dz_flags", 64'(f), 64'(6'b001000));
        @(negedge clk);
        chk("dz_sticky", 64'(sticky_flags), 64'(6'b001000));

        // Divider never answers: forced qNaN with timeout+invalid
        do_op(32'h40000000, 32'h40000000, RM_RTZ, 32'h3F800000, 5'b00000, NEVER, -1, 0, 1'b0, 1'b0, lat, d, f);
        chk("to_lat", 64'(lat), 64'(68));
        chk("to_data", 64'(d), 64'(32'h7FC00000));
        chk("to_flags", 64'(f), 64'(6'b110000));

        // 10 / 5 = 2: done on first WAIT cycle, stale done in SETTLE, consumer stalls 10 cycles
        do_op(32'h41200000, 32'h40A00000, RM_RUP, 32'h40000000, 5'b00000, 0, 2, 10, 1'b0, 1'b0, lat, d, f);
        chk("stall_lat", 64'(lat), 64'(5));
        chk("stall_data", 64'(d), 64'(32'h40000000));

        // Done on the very last timeout cycle wins over expiry
        do_op(32'h3F800000, 32'h3F800000, RM_RDN, 32'h3F800000, 5'b00000, TIMEOUT - 1, -1, 0, 1'b0, 1'b0, lat, d, f);
        chk("edge_lat", 64'(lat), 64'(68));
        chk("edge_data", 64'(d), 64'(32'h3F800000));
        chk("edge_flags", 64'(f), 64'(0));

        // req_valid held with other operands and rsp_ready high while busy
        do_op(32'h40400000, 32'h3F800000, RM_RTZ, 32'h40400000, 5'b00000, 2, -1, 0, 1'b0, 1'b1, lat, d, f);
        chk("junk_lat", 64'(lat), 64'(7));
        chk("junk_data", 64'(d), 64'(32'h40400000));

        // Reset in the middle of WAIT: nothing comes out afterwards
        op_out = 32'h3F000000; op_f5 = 5'b00000; op_d = 30; op_stale = -1;
        @(posedge clk); #1;
        req_valid = 1'b1; req_a = 32'h3F800000; req_b = 32'h40000000; req_rm = RM_RNE;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_ready", 64'(req_ready), 64'(1));
        chk("mid_rst_act", 64'(div_act), 64'(0));
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 64'(req_ready), 64'(1));
        chk("post_rst_act", 64'(div_act), 64'(0));
        vseen = 0;
        repeat (40) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) vseen++;
        end
        chk("post_rst_no_rsp", 64'(vseen), 64'(0));

        // Sticky accumulation across two ops, then explicit clear
        do_op(32'h3F800000, 32'h00000000, RM_RNE, 32'h7F800000, 5'b01000, 1, -1, 0, 1'b0, 1'b0, lat, d, f);
        do_op(32'h40000000, 32'h40400000, RM_RNE, 32'h3F2AAAAB, 5'b00001, 3, -1, 0, 1'b0, 1'b0, lat, d, f);
        chk("nx_data", 64'(d), 64'(32'h3F2AAAAB));
        @(negedge clk);
        chk("sticky_acc", 64'(sticky_flags), 64'(6'b001001));
        @(posedge clk); #1 clr_flags = 1'b1;
        @(posedge clk); #1 clr_flags = 1'b0;
        @(negedge clk);
        chk("sticky_clr", 64'(sticky_flags), 64'(0));

        // Clear coinciding with a handshake keeps only that response's flags
        do_op(32'h40000000, 32'h40400000, RM_RNE, 32'h3F2AAAAB, 5'b00001, 1, -1, 0, 1'b0, 1'b0, lat, d, f);
        do_op(32'h7F000000, 32'h3E800000, RM_RNE, 32'h7F800000, 5'b00101, 1, -1, 2, 1'b1, 1'b0, lat, d, f);
        chk("ov_flags", 64'(f), 64'(6'b000101));
        @(negedge clk);
        chk("sticky_clr_hs", 64'(sticky_flags), 64'(6'b000101));

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
